// File: rtl/stream_ap_n.sv
// ============================================================================
// Module   : stream_ap_n
// Brief    : Pops up to N_POP leading stream elements into parallel slots,
//            then forwards the rest of the stream. Optional macro
//            STREAM_AP_N_SKID_EN registers the pass path via a 2-entry skid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_ap_n #(
    parameter int N_POP = 2,
    parameter int W     = 8,
    parameter int CNT_W = $clog2(N_POP + 1)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [W-1:0]       sIn,
    input  logic               sIn_valid,
    output logic               sIn_ready,
    input  logic               sIn_last,
    output logic [W-1:0]       sOut,
    output logic               sOut_valid,
    input  logic               sOut_ready,
    output logic               sOut_last,
    output logic [N_POP*W-1:0] dOut,
    output logic [CNT_W-1:0]   dOut_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2,
        PASS    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N_POP*W-1:0] dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               short_q, short_d;

    logic               pass_done;
    logic               pass_sin_ready;

`ifdef STREAM_AP_N_SKID_EN
    // Two entries give full throughput while sIn_ready depends only on state.
    logic [W-1:0] mem_q [2];
    logic [1:0]   mem_last_q;
    logic         wr_q, rd_q;
    logic [1:0]   fill_q;
    logic         got_last_q;
    logic         push, pop;

    assign pass_sin_ready = (state_q == PASS) && (fill_q != 2'd2) && !got_last_q;
    assign push           = sIn_valid && pass_sin_ready;
    assign sOut_valid     = (fill_q != 2'd0);
    assign sOut           = sOut_valid ? mem_q[rd_q] : '0;
    assign sOut_last      = sOut_valid && mem_last_q[rd_q];
    assign pop            = sOut_valid && sOut_ready;
    assign pass_done      = pop && mem_last_q[rd_q];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            mem_last_q <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            fill_q     <= 2'd0;
            got_last_q <= 1'b0;
        end else if (state_q != PASS) begin
            mem_last_q <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            fill_q     <= 2'd0;
            got_last_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q]      <= sIn;
                mem_last_q[wr_q] <= sIn_last;
                wr_q             <= ~wr_q;
                if (sIn_last) begin
                    got_last_q <= 1'b1;
                end
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 2'd1;
                2'b01:   fill_q <= fill_q - 2'd1;
                default: fill_q <= fill_q;
            endcase
        end
    end
`else
    wire w_pass = (state_q == PASS);

    assign pass_sin_ready = w_pass && sOut_ready;
    assign sOut           = w_pass ? sIn : '0;
    assign sOut_valid     = w_pass && sIn_valid;
    assign sOut_last      = w_pass && sIn_last;
    assign pass_done      = sIn_valid && sOut_ready && sIn_last;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            dout_q  <= '0;
            cnt_q   <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        cnt_d     = cnt_q;
        short_d   = short_q;
        out_valid = 1'b0;
        sIn_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dout_d  = '0;
                    cnt_d   = '0;
                    short_d = 1'b0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                sIn_ready = 1'b1;
                if (sIn_valid) begin
                    for (int k = 0; k < N_POP; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            dout_d[k*W +: W] = sIn;
                        end
                    end
                    if (cnt_q != CNT_W'(N_POP)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (sIn_last) begin
                        short_d = 1'b1;
                        state_d = EMIT;
                    end else if (cnt_q == CNT_W'(N_POP - 1)) begin
                        short_d = 1'b0;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = short_q ? IDLE : PASS;
                end
            end
            PASS: begin
                sIn_ready = pass_sin_ready;
                if (pass_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = nrst && (state_q == IDLE);
    assign dOut     = dout_q;
    assign dOut_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_ap_n.sv
// ============================================================================
// Module   : tb_stream_ap_n
// Brief    : Directed self-checking bench for stream_ap_n (N_POP=2, W=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_ap_n;

    localparam int N_POP = 2;
    localparam int W     = 8;
    localparam int CNT_W = $clog2(N_POP + 1);

    logic               clk;
    logic               nrst;
    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       sIn;
    logic               sIn_valid;
    logic               sIn_ready;
    logic               sIn_last;
    logic [W-1:0]       sOut;
    logic               sOut_valid;
    logic               sOut_ready;
    logic               sOut_last;
    logic [N_POP*W-1:0] dOut;
    logic [CNT_W-1:0]   dOut_cnt;

    int n_total;
    int n_pass;

    stream_ap_n #(.N_POP(N_POP), .W(W)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sIn        (sIn),
        .sIn_valid  (sIn_valid),
        .sIn_ready  (sIn_ready),
        .sIn_last   (sIn_last),
        .sOut       (sOut),
        .sOut_valid (sOut_valid),
        .sOut_ready (sOut_ready),
        .sOut_last  (sOut_last),
        .dOut       (dOut),
        .dOut_cnt   (dOut_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All stimulus tasks begin and end on a falling edge.
    task automatic invoke();
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] v, input logic last);
        sIn       = v;
        sIn_valid = 1'b1;
        sIn_last  = last;
        @(posedge clk);
        @(negedge clk);
        sIn_valid = 1'b0;
        sIn_last  = 1'b0;
    endtask

    task automatic pulse_out_ready();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [W-1:0] got[$];
    int           idx;

    initial begin
        n_total    = 0;
        n_pass     = 0;
        nrst       = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        sIn        = '0;
        sIn_valid  = 1'b0;
        sIn_last   = 1'b0;
        sOut_ready = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sin_ready", sIn_ready, 0);
        chk("rst_sout_valid", sOut_valid, 0);
        chk("rst_dout", dOut, 0);
        chk("rst_cnt", dOut_cnt, 0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 1);

        // Stream 1,2,3,4(last): pop 1,2 then pass 3,4
        invoke();
        chk("t1_collect_sin_ready", sIn_ready, 1);
        chk("t1_collect_in_ready", in_ready, 0);
        push(8'd1, 1'b0);
        push(8'd2, 1'b0);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_dout", dOut, 16'h0201);
        chk("t1_cnt", dOut_cnt, 2);
        chk("t1_emit_sin_ready", sIn_ready, 0);
        pulse_out_ready();
        chk("t1_out_valid_drop", out_valid, 0);
        sOut_ready = 1'b1;
        sIn = 8'd3; sIn_valid = 1'b1; sIn_last = 1'b0;
        #1;
        chk("t1_sout3", sOut, 3);
        chk("t1_sout3_valid", sOut_valid, 1);
        chk("t1_sout3_last", sOut_last, 0);
        chk("t1_pass_sin_ready", sIn_ready, 1);
        @(posedge clk);
        @(negedge clk);
        sIn = 8'd4; sIn_last = 1'b1;
        #1;
        chk("t1_sout4", sOut, 4);
        chk("t1_sout4_last", sOut_last, 1);
        @(posedge clk);
        @(negedge clk);
        sIn_valid = 1'b0; sIn_last = 1'b0; sOut_ready = 1'b0;
        #1;
        chk("t1_back_idle", in_ready, 1);
        chk("t1_sout_quiet", sOut_valid, 0);

        // Stream 7(last): short pop, no pass phase
        invoke();
        sOut_ready = 1'b1;
        push(8'd7, 1'b1);
        chk("t2_out_valid", out_valid, 1);
        chk("t2_dout", dOut, 16'h0007);
        chk("t2_cnt", dOut_cnt, 1);
        chk("t2_sout_valid", sOut_valid, 0);
        pulse_out_ready();
        chk("t2_idle", in_ready, 1);
        sIn = 8'd9; sIn_valid = 1'b1;
        #1;
        chk("t2_no_pass", sOut_valid, 0);
        sIn_valid = 1'b0;

        // Stream 5,6(last): exactly N_POP long
        invoke();
        push(8'd5, 1'b0);
        push(8'd6, 1'b1);
        chk("t3_dout", dOut, 16'h0605);
        chk("t3_cnt", dOut_cnt, 2);
        chk("t3_sout_valid", sOut_valid, 0);
        pulse_out_ready();
        chk("t3_idle", in_ready, 1);
        sOut_ready = 1'b0;

        // Gaps on sIn and stalled out_ready
        invoke();
        push(8'd1, 1'b0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_gap_sin_ready", sIn_ready, 1);
            chk("t4_gap_out_valid", out_valid, 0);
        end
        in_valid = 1'b1;
        push(8'd2, 1'b0);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_stall_valid", out_valid, 1);
            chk("t4_stall_dout", dOut, 16'h0201);
            chk("t4_stall_cnt", dOut_cnt, 2);
        end
        pulse_out_ready();

        // Pass with toggling sOut_ready over 10..15(last)
        idx = 0;
        got.delete();
        for (int c = 0; c < 40 && idx < 6; c++) begin
            @(negedge clk);
            sOut_ready = (c % 2 == 0);
            sIn        = W'(10 + idx);
            sIn_valid  = 1'b1;
            sIn_last   = (idx == 5);
            #1;
            chk("t5_ready_mirror", sIn_ready, sOut_ready);
            if (sOut_valid && sOut_ready) begin
                got.push_back(sOut);
                idx++;
            end
        end
        @(negedge clk);
        sIn_valid = 1'b0; sIn_last = 1'b0; sOut_ready = 1'b0;
        chk("t5_count", got.size(), 6);
        for (int i = 0; i < got.size(); i++) begin
            chk("t5_seq", got[i], 10 + i);
        end
        chk("t5_idle", in_ready, 1);

        // Async reset mid-pass, then a fresh invocation
        invoke();
        push(8'd1, 1'b0);
        push(8'd2, 1'b0);
        pulse_out_ready();
        sOut_ready = 1'b1;
        sIn = 8'd3; sIn_valid = 1'b1;
        #1;
        chk("t6_pre_rst_sout_valid", sOut_valid, 1);
        #1;
        nrst = 1'b0;
        #1;
        chk("t6_rst_sout_valid", sOut_valid, 0);
        chk("t6_rst_sin_ready", sIn_ready, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_dout", dOut, 0);
        chk("t6_rst_cnt", dOut_cnt, 0);
        @(negedge clk);
        sIn_valid = 1'b0;
        nrst = 1'b1;
        #1;
        chk("t6_release_idle", in_ready, 1);
        invoke();
        push(8'd1, 1'b0);
        push(8'd2, 1'b0);
        chk("t6_dout", dOut, 16'h0201);
        chk("t6_cnt", dOut_cnt, 2);
        pulse_out_ready();
        sIn = 8'd3; sIn_valid = 1'b1; sIn_last = 1'b1;
        #1;
        chk("t6_sout", sOut, 3);
        chk("t6_sout_last", sOut_last, 1);
        chk("t6_sout_valid", sOut_valid, 1);
        @(posedge clk);
        @(negedge clk);
        sIn_valid = 1'b0; sIn_last = 1'b0;
        #1;
        chk("t6_final_idle", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
